// File: rtl/game_pkg.sv
// Screen geometry, sprite sizes, colours and small helpers shared by the game blocks.
package game_pkg;

   localparam logic [9:0] SCREEN_LEFT       = 10'd0;
   localparam logic [9:0] SCREEN_RIGHT      = 10'd640;
   localparam logic [9:0] SCREEN_TOP        = 10'd0;
   localparam logic [9:0] SCREEN_BOTTOM     = 10'd480;
   localparam logic [9:0] SCOREBOARD_BOTTOM = 10'd60;

   localparam logic [9:0] SPACESHIP_TOP         = 10'd415;
   localparam logic [9:0] HALF_SPACESHIP_LENGTH = 10'd20;
   localparam logic [9:0] HALF_ALIEN_HEIGHT     = 10'd8;
   localparam logic [9:0] HALF_LASER_HEIGHT     = 10'd5;
   localparam logic [9:0] HALF_LASER_LENGTH     = 10'd1;

   // Lowest centre a laser may occupy before it counts as off the bottom.
   localparam logic [9:0] LASER_Y_MAX = SCREEN_BOTTOM - HALF_LASER_HEIGHT;

   localparam int unsigned NUM_LANES = 3;

   // Colours are packed [BLUE|GREEN|RED].
   localparam logic [7:0] COLOR_BLACK = 8'b00000000;
   localparam logic [7:0] COLOR_RED   = 8'b00000111;
   localparam logic [7:0] COLOR_GREEN = 8'b00111000;
   localparam logic [7:0] COLOR_BLUE  = 8'b11000000;
   localparam logic [7:0] COLOR_WHITE = 8'b11111111;

   typedef enum logic {LaneIdle, LaneActive} lane_state_e;

   function automatic logic [9:0] sat_sub(input logic [9:0] a, input logic [9:0] b);
      return (a > b) ? (a - b) : 10'd0;
   endfunction

   function automatic logic [9:0] sat_add(input logic [9:0] a, input logic [9:0] b);
      logic [10:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[10] ? 10'h3FF : sum[9:0];
   endfunction

endpackage

// File: rtl/alien_laser_lane.sv
// One alien laser: spawns on fire, descends one step per frame, retires on ship hit,
// bottom exit, barrier hit or leaving game mode.
module alien_laser_lane
   import game_pkg::*;
#(
   parameter int unsigned MOVE_DOWN = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       mode_i,
   input  logic       frame_tick_i,
   input  logic       fire_i,
   input  logic [9:0] spawn_x_i,
   input  logic [9:0] spawn_y_i,
   input  logic       barrier_hit_i,
   input  logic [9:0] spaceship_x_i,
   input  logic [9:0] pix_x_i,
   input  logic [9:0] pix_y_i,
   output logic [9:0] x_o,
   output logic [9:0] y_o,
   output logic       active_o,
   output logic       pixel_hit_o
);

   lane_state_e state_q, state_d;
   logic [9:0]  x_q, x_d;
   logic [9:0]  y_q, y_d;

   logic [9:0] y_step;
   logic [9:0] ship_c;
   logic [9:0] ship_lo;
   logic [9:0] ship_hi;
   logic       ship_hit;

   assign y_step = y_q + 10'(MOVE_DOWN);

   // Clamp keeps the lower window bound from wrapping near the left edge.
   assign ship_c   = (spaceship_x_i < HALF_SPACESHIP_LENGTH) ? HALF_SPACESHIP_LENGTH
                                                             : spaceship_x_i;
   assign ship_lo  = ship_c - HALF_SPACESHIP_LENGTH;
   assign ship_hi  = ship_c + HALF_SPACESHIP_LENGTH;
   assign ship_hit = (y_q >= SPACESHIP_TOP) && (x_q >= ship_lo) && (x_q <= ship_hi);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= LaneIdle;
         x_q     <= 10'd0;
         y_q     <= 10'd0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      if (!mode_i || barrier_hit_i) begin
         state_d = LaneIdle;
         x_d     = 10'd0;
         y_d     = 10'd0;
      end else if (frame_tick_i) begin
         unique case (state_q)
            LaneIdle: begin
               if (fire_i) begin
                  state_d = LaneActive;
                  x_d     = spawn_x_i;
                  y_d     = spawn_y_i;
               end
            end
            LaneActive: begin
               if (ship_hit || (y_step > LASER_Y_MAX)) begin
                  state_d = LaneIdle;
                  x_d     = 10'd0;
                  y_d     = 10'd0;
               end else begin
                  y_d = y_step;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      active_o    = (state_q == LaneActive);
      x_o         = x_q;
      y_o         = y_q;
      pixel_hit_o = active_o
                    && (pix_x_i >= sat_sub(x_q, HALF_LASER_LENGTH))
                    && (pix_x_i <= sat_add(x_q, HALF_LASER_LENGTH))
                    && (pix_y_i >= sat_sub(y_q, HALF_LASER_HEIGHT))
                    && (pix_y_i <= sat_add(y_q, HALF_LASER_HEIGHT));
   end

endmodule

// File: rtl/alien_laser_ctrl.sv
// Alien laser controller: shared LFSR lane picker and fire cooldown driving three laser lanes.
module alien_laser_ctrl
   import game_pkg::*;
#(
   parameter int unsigned FIRE_PERIOD       = 90,
   parameter int unsigned MOVE_DOWN         = 2,
   parameter logic [7:0]  LFSR_SEED         = 8'hA5,
   parameter logic [7:0]  COLOR_ALIEN_LASER = 8'b00000111
) (
   input  logic        clk,
   input  logic        restart,
   input  logic        mode,
   input  logic [9:0]  xCoord,
   input  logic [9:0]  yCoord,
   input  logic [29:0] alien_xCoord,
   input  logic [29:0] alien_yCoord,
   input  logic [2:0]  alien_alive,
   input  logic [9:0]  spaceship_xCoord,
   input  logic [2:0]  barrAlienLaserHit,
   output logic [29:0] alien_laser_xCoord,
   output logic [29:0] alien_laser_yCoord,
   output logic [7:0]  rgb_alien_laser,
   output logic        is_alien_laser
);

   localparam logic [6:0] COOL_RELOAD  = 7'(FIRE_PERIOD - 1);
   localparam logic [9:0] SPAWN_OFFSET = HALF_ALIEN_HEIGHT + HALF_LASER_HEIGHT;

   logic       frame_tick;
   logic [7:0] lfsr_q, lfsr_d;
   logic [6:0] cool_q, cool_d;
   logic       lfsr_fb;
   logic       fire_attempt;
   logic [1:0] fire_lane;

   logic [NUM_LANES-1:0] fire;
   logic [NUM_LANES-1:0] active;
   logic [NUM_LANES-1:0] pixel_hit;

   assign frame_tick = (xCoord == 10'd0) && (yCoord == 10'd0);

   // Taps for x^8+x^6+x^5+x^4+1, shifting towards the MSB.
   assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

   always_ff @(posedge clk or posedge restart) begin
      if (restart) begin
         lfsr_q <= LFSR_SEED;
         cool_q <= COOL_RELOAD;
      end else begin
         lfsr_q <= lfsr_d;
         cool_q <= cool_d;
      end
   end

   always_comb begin
      lfsr_d = lfsr_q;
      cool_d = cool_q;
      if (frame_tick) begin
         lfsr_d = {lfsr_q[6:0], lfsr_fb};
      end
      if (!mode) begin
         cool_d = COOL_RELOAD;
      end else if (frame_tick) begin
         cool_d = (cool_q != 7'd0) ? (cool_q - 7'd1) : COOL_RELOAD;
      end
   end

   // Lane choice uses the pre-advance LFSR; a value of 3 is a deliberate miss.
   assign fire_attempt = mode && frame_tick && (cool_q == 7'd0);
   assign fire_lane    = lfsr_q[1:0];

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      // Gating on pre-edge activity stops a lane retired this frame from refiring at once.
      assign fire[i] = fire_attempt && (fire_lane == 2'(i)) && !active[i] && alien_alive[i];

      alien_laser_lane #(
         .MOVE_DOWN (MOVE_DOWN)
      ) u_lane (
         .clk_i         (clk),
         .rst_i         (restart),
         .mode_i        (mode),
         .frame_tick_i  (frame_tick),
         .fire_i        (fire[i]),
         .spawn_x_i     (alien_xCoord[10*i +: 10]),
         .spawn_y_i     (alien_yCoord[10*i +: 10] + SPAWN_OFFSET),
         .barrier_hit_i (barrAlienLaserHit[i]),
         .spaceship_x_i (spaceship_xCoord),
         .pix_x_i       (xCoord),
         .pix_y_i       (yCoord),
         .x_o           (alien_laser_xCoord[10*i +: 10]),
         .y_o           (alien_laser_yCoord[10*i +: 10]),
         .active_o      (active[i]),
         .pixel_hit_o   (pixel_hit[i])
      );
   end

   always_comb begin
      is_alien_laser  = |pixel_hit;
      rgb_alien_laser = is_alien_laser ? COLOR_ALIEN_LASER : 8'd0;
   end

endmodule

// File: tb/tb_alien_laser_ctrl.sv
// Directed bench for alien_laser_ctrl with a behavioural lane/LFSR reference model.
module tb_alien_laser_ctrl;

   logic        clk = 1'b0;
   logic        restart;
   logic        mode;
   logic [9:0]  xCoord, yCoord;
   logic [29:0] alien_xCoord, alien_yCoord;
   logic [2:0]  alien_alive;
   logic [9:0]  spaceship_xCoord;
   logic [2:0]  barrAlienLaserHit;
   logic [29:0] alien_laser_xCoord, alien_laser_yCoord;
   logic [7:0]  rgb_alien_laser;
   logic        is_alien_laser;

   int checks = 0;
   int errors = 0;

   logic [7:0] m_lfsr;
   logic [6:0] m_cd;
   logic       m_act [3];
   logic [9:0] m_x   [3];
   logic [9:0] m_y   [3];

   typedef struct {
      logic [9:0] px;
      logic [9:0] py;
      logic       exp_hit;
      logic [7:0] exp_rgb;
   } pix_vec_t;

   pix_vec_t vecs [11];

   alien_laser_ctrl dut (
      .clk                (clk),
      .restart            (restart),
      .mode               (mode),
      .xCoord             (xCoord),
      .yCoord             (yCoord),
      .alien_xCoord       (alien_xCoord),
      .alien_yCoord       (alien_yCoord),
      .alien_alive        (alien_alive),
      .spaceship_xCoord   (spaceship_xCoord),
      .barrAlienLaserHit  (barrAlienLaserHit),
      .alien_laser_xCoord (alien_laser_xCoord),
      .alien_laser_yCoord (alien_laser_yCoord),
      .rgb_alien_laser    (rgb_alien_laser),
      .is_alien_laser     (is_alien_laser)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic m_park(input int i);
      m_act[i] = 1'b0;
      m_x[i]   = 10'd0;
      m_y[i]   = 10'd0;
   endtask

   task automatic m_reset();
      m_lfsr = 8'hA5;
      m_cd   = 7'd89;
      for (int i = 0; i < 3; i++) m_park(i);
   endtask

   task automatic check_coords(input string name);
      logic [29:0] ex, ey;
      for (int i = 0; i < 3; i++) begin
         ex[10*i +: 10] = m_x[i];
         ey[10*i +: 10] = m_y[i];
      end
      check(name, {alien_laser_xCoord, alien_laser_yCoord}, {ex, ey});
   endtask

   // One frame_tick edge; called in the low clock phase, returns in the low phase.
   task automatic tick(input logic [2:0] bhit, output logic att, output logic [1:0] lane);
      logic       act_pre [3];
      logic [9:0] c, lo, hi, yn;
      int         li;
      lane = m_lfsr[1:0];
      li   = int'(lane);
      att  = 1'b0;
      c  = (spaceship_xCoord < 10'd20) ? 10'd20 : spaceship_xCoord;
      lo = c - 10'd20;
      hi = c + 10'd20;
      for (int i = 0; i < 3; i++) act_pre[i] = m_act[i];
      for (int i = 0; i < 3; i++) begin
         if (!mode || bhit[i]) m_park(i);
         else if (m_act[i]) begin
            yn = m_y[i] + 10'd2;
            if (m_y[i] >= 10'd415 && m_x[i] >= lo && m_x[i] <= hi) m_park(i);
            else if (yn > 10'd475) m_park(i);
            else m_y[i] = yn;
         end
      end
      if (!mode) m_cd = 7'd89;
      else if (m_cd != 7'd0) m_cd = m_cd - 7'd1;
      else begin
         m_cd = 7'd89;
         att  = 1'b1;
         if (li < 3) begin
            if (!act_pre[li] && alien_alive[li] && !bhit[li]) begin
               m_act[li] = 1'b1;
               m_x[li]   = alien_xCoord[10*li +: 10];
               m_y[li]   = alien_yCoord[10*li +: 10] + 10'd13;
            end
         end
      end
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      xCoord = 10'd0;
      yCoord = 10'd0;
      barrAlienLaserHit = bhit;
      @(negedge clk);
      xCoord = 10'd639;
      yCoord = 10'd479;
      barrAlienLaserHit = 3'b000;
      #1 check_coords("coords");
   endtask

   // One non-tick edge, optionally with barrier hits.
   task automatic edge_only(input logic [2:0] bhit);
      barrAlienLaserHit = bhit;
      @(negedge clk);
      barrAlienLaserHit = 3'b000;
      if (!mode) begin
         m_cd = 7'd89;
         for (int i = 0; i < 3; i++) m_park(i);
      end else begin
         for (int i = 0; i < 3; i++) if (bhit[i]) m_park(i);
      end
      #1 check_coords("coords_edge");
   endtask

   task automatic set_mode(input logic v);
      mode = v;
      edge_only(3'b000);
   endtask

   // Slip the cooldown one LFSR step relative to the lane sequence.
   task automatic shift_phase();
      logic       att;
      logic [1:0] lane;
      set_mode(1'b0);
      tick(3'b000, att, lane);
      set_mode(1'b1);
   endtask

   task automatic wait_lane(input int want);
      logic       att, ok;
      logic [1:0] lane;
      ok = 1'b0;
      for (int n = 0; n < 40 && !ok; n++) begin
         att = 1'b0;
         for (int k = 0; k < 100 && !att; k++) tick(3'b000, att, lane);
         if (att && int'(lane) == want) ok = 1'b1;
         else if (n % 6 == 5) shift_phase();
      end
      check("wait_lane", ok, 1'b1);
   endtask

   initial begin : main
      logic       att, found, pre;
      logic [1:0] lane;
      logic [9:0] y2, exp_y;
      int         li;

      restart           = 1'b1;
      mode              = 1'b0;
      xCoord            = 10'd639;
      yCoord            = 10'd479;
      alien_xCoord      = {10'd400, 10'd200, 10'd100};
      alien_yCoord      = {10'd100, 10'd100, 10'd100};
      alien_alive       = 3'b010;
      spaceship_xCoord  = 10'd600;
      barrAlienLaserHit = 3'b000;
      #2;
      check("reset_coords", {alien_laser_xCoord, alien_laser_yCoord}, 60'd0);
      check("reset_is", is_alien_laser, 1'b0);
      check("reset_rgb", rgb_alien_laser, 8'd0);
      @(negedge clk);
      @(negedge clk);
      restart = 1'b0;
      mode    = 1'b1;
      m_reset();

      // Fire and descend on lane 1.
      wait_lane(1);
      check("spawn_x1", alien_laser_xCoord[19:10], 10'd200);
      check("spawn_y1", alien_laser_yCoord[19:10], 10'd113);
      vecs[0]  = '{10'd200, 10'd113, 1'b1, 8'b00000111};
      vecs[1]  = '{10'd202, 10'd113, 1'b0, 8'd0};
      vecs[2]  = '{10'd201, 10'd113, 1'b1, 8'b00000111};
      vecs[3]  = '{10'd199, 10'd113, 1'b1, 8'b00000111};
      vecs[4]  = '{10'd198, 10'd113, 1'b0, 8'd0};
      vecs[5]  = '{10'd200, 10'd108, 1'b1, 8'b00000111};
      vecs[6]  = '{10'd200, 10'd107, 1'b0, 8'd0};
      vecs[7]  = '{10'd200, 10'd118, 1'b1, 8'b00000111};
      vecs[8]  = '{10'd200, 10'd119, 1'b0, 8'd0};
      vecs[9]  = '{10'd201, 10'd118, 1'b1, 8'b00000111};
      vecs[10] = '{10'd202, 10'd118, 1'b0, 8'd0};
      for (int v = 0; v < 11; v++) begin
         xCoord = vecs[v].px;
         yCoord = vecs[v].py;
         #1;
         check($sformatf("pix_is_%0d", v), is_alien_laser, vecs[v].exp_hit);
         check($sformatf("pix_rgb_%0d", v), rgb_alien_laser, vecs[v].exp_rgb);
         @(negedge clk);
      end
      xCoord = 10'd639;
      yCoord = 10'd479;
      tick(3'b000, att, lane);
      check("descend_115", alien_laser_yCoord[19:10], 10'd115);
      tick(3'b000, att, lane);
      check("descend_117", alien_laser_yCoord[19:10], 10'd117);
      tick(3'b000, att, lane);
      check("descend_119", alien_laser_yCoord[19:10], 10'd119);

      // Asynchronous restart in the middle of a frame.
      xCoord = 10'd200;
      yCoord = 10'd119;
      #1 check("pre_restart_is", is_alien_laser, 1'b1);
      restart = 1'b1;
      #1;
      check("restart_coords", {alien_laser_xCoord, alien_laser_yCoord}, 60'd0);
      check("restart_is", is_alien_laser, 1'b0);
      check("restart_rgb", rgb_alien_laser, 8'd0);
      @(negedge clk);
      restart = 1'b0;
      xCoord  = 10'd639;
      yCoord  = 10'd479;
      m_reset();

      // First attempt lands on frame 90 after release.
      alien_alive = 3'b111;
      for (int k = 0; k < 89; k++) tick(3'b000, att, lane);
      check("first_quiet", {alien_laser_xCoord, alien_laser_yCoord}, 60'd0);
      tick(3'b000, att, lane);
      li = int'(lane);
      if (li < 3) check("first_fire_y", alien_laser_yCoord[10*li +: 10], 10'd113);
      else check("first_fire_none", {alien_laser_xCoord, alien_laser_yCoord}, 60'd0);

      // Bottom exit, including the 475 boundary that still survives.
      set_mode(1'b0);
      set_mode(1'b1);
      alien_alive  = 3'b010;
      alien_yCoord = {10'd100, 10'd460, 10'd100};
      wait_lane(1);
      check("bottom_spawn_473", alien_laser_yCoord[19:10], 10'd473);
      tick(3'b000, att, lane);
      check("bottom_keep_475", alien_laser_yCoord[19:10], 10'd475);
      tick(3'b000, att, lane);
      check("bottom_exit_a", {alien_laser_xCoord[19:10], alien_laser_yCoord[19:10]}, 20'd0);
      alien_yCoord = {10'd100, 10'd461, 10'd100};
      wait_lane(1);
      check("bottom_spawn_474", alien_laser_yCoord[19:10], 10'd474);
      tick(3'b000, att, lane);
      check("bottom_exit_b", {alien_laser_xCoord[19:10], alien_laser_yCoord[19:10]}, 20'd0);

      // Ship hit window.
      alien_xCoord     = {10'd400, 10'd300, 10'd100};
      alien_yCoord     = {10'd100, 10'd402, 10'd100};
      spaceship_xCoord = 10'd310;
      wait_lane(1);
      check("ship_spawn", {alien_laser_xCoord[19:10], alien_laser_yCoord[19:10]},
            {10'd300, 10'd415});
      tick(3'b000, att, lane);
      check("ship_hit_310", {alien_laser_xCoord[19:10], alien_laser_yCoord[19:10]}, 20'd0);
      spaceship_xCoord = 10'd330;
      wait_lane(1);
      tick(3'b000, att, lane);
      check("ship_miss_330", {alien_laser_xCoord[19:10], alien_laser_yCoord[19:10]},
            {10'd300, 10'd417});
      spaceship_xCoord = 10'd320;
      tick(3'b000, att, lane);
      check("ship_edge_320", {alien_laser_xCoord[19:10], alien_laser_yCoord[19:10]}, 20'd0);
      spaceship_xCoord = 10'd600;

      // Barrier hits, alone and against frame updates and mode changes.
      alien_alive = 3'b001;
      wait_lane(0);
      check("bar_spawn", {alien_laser_xCoord[9:0], alien_laser_yCoord[9:0]},
            {10'd100, 10'd113});
      tick(3'b001, att, lane);
      check("bar_on_tick", {alien_laser_xCoord[9:0], alien_laser_yCoord[9:0]}, 20'd0);
      wait_lane(0);
      edge_only(3'b001);
      check("bar_no_tick", {alien_laser_xCoord[9:0], alien_laser_yCoord[9:0]}, 20'd0);
      wait_lane(0);
      mode = 1'b0;
      tick(3'b001, att, lane);
      check("bar_mode0", {alien_laser_xCoord, alien_laser_yCoord}, 60'd0);
      set_mode(1'b1);

      // Dead lane selected, then cooldown reload timing.
      alien_alive = 3'b000;
      found = 1'b0;
      for (int n = 0; n < 3000 && !found; n++) begin
         if (m_cd == 7'd0 && m_lfsr[1:0] == 2'd2) alien_alive = 3'b011;
         tick(3'b000, att, lane);
         if (att && lane == 2'd2) found = 1'b1;
         else if (n % 500 == 499) shift_phase();
      end
      check("dead_reached", found, 1'b1);
      check("dead_no_spawn", {alien_laser_xCoord[29:20], alien_laser_yCoord[29:20]}, 20'd0);
      alien_alive  = 3'b111;
      alien_yCoord = {10'd100, 10'd100, 10'd100};
      for (int k = 0; k < 89; k++) tick(3'b000, att, lane);
      check("reload_quiet", {alien_laser_xCoord, alien_laser_yCoord}, 60'd0);
      tick(3'b000, att, lane);
      li = int'(lane);
      if (li < 3) check("reload_fire_y", alien_laser_yCoord[10*li +: 10], 10'd113);
      else check("reload_none", {alien_laser_xCoord, alien_laser_yCoord}, 60'd0);

      // Busy lane: an attempt on an active lane must not respawn it.
      set_mode(1'b0);
      set_mode(1'b1);
      alien_alive  = 3'b100;
      alien_yCoord = {10'd0, 10'd100, 10'd100};
      found = 1'b0;
      for (int n = 0; n < 6000 && !found; n++) begin
         pre = m_act[2];
         y2  = m_y[2];
         tick(3'b000, att, lane);
         if (att && lane == 2'd2 && pre) begin
            found = 1'b1;
            exp_y = (y2 + 10'd2 > 10'd475) ? 10'd0 : y2 + 10'd2;
            check("busy_no_respawn", alien_laser_yCoord[29:20], exp_y);
         end else if (n % 400 == 399) shift_phase();
      end
      check("busy_reached", found, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alien_laser_ctrl.md
Name: alien_laser_ctrl

Overview:
- Generates, moves and retires the three alien lasers; one lane per alien column.
- Sits directly upstream of the spaceship block.
- Its packed alien_laser_xCoord/alien_laser_yCoord buses feed the spaceship's hit check.
- Its pixel outputs feed the VGA colour mux alongside the spaceship and laser pixels.

Parameters:
- FIRE_PERIOD, 90: frames between fire attempts.
- MOVE_DOWN, 2: pixels per frame a live laser descends.
- LFSR_SEED, 8'hA5: reset value of the lane-select LFSR.
- COLOR_ALIEN_LASER, 8'b00000111: pixel colour of a live laser, [BLUE|GREEN|RED].

Ports:
- clk  in  1  system clock
- restart  in  1  asynchronous active-high reset
- mode  in  1  0 = attract/idle, 1 = game running
- xCoord  in  10  current VGA pixel x
- yCoord  in  10  current VGA pixel y
- alien_xCoord  in  30  packed centre x of aliens 0..2, [9:0] = alien 0
- alien_yCoord  in  30  packed centre y of aliens 0..2
- alien_alive  in  3  per-alien alive flag
- spaceship_xCoord  in  10  spaceship centre x
- barrAlienLaserHit  in  3  per-lane barrier-hit pulse
- alien_laser_xCoord  out  30  packed laser centre x
- alien_laser_yCoord  out  30  packed laser centre y
- rgb_alien_laser  out  8  laser pixel colour
- is_alien_laser  out  1  current pixel lies inside any live laser

Behaviour:
- frame_tick = (xCoord==0 && yCoord==0), combinational. All motion and firing happens only on clk edges where frame_tick=1.
- Per-lane state: IDLE/ACTIVE, x[9:0], y[9:0].
  - IDLE parks at x=0, y=0. y=0 never satisfies the spaceship hit window (y>=415).
- Shared state: 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) advanced once per frame_tick; 7-bit cooldown counter.
- Reset (restart=1, async): all lanes IDLE at (0,0); LFSR=LFSR_SEED; cooldown=FIRE_PERIOD-1; rgb_alien_laser=0; is_alien_laser=0.
- Priority per clk edge: restart > mode==0 > barrier hit > frame update.
- mode==0: all lanes forced IDLE; cooldown reloaded to FIRE_PERIOD-1; LFSR keeps running only on frame ticks.
- barrAlienLaserHit[i]=1 on any edge with mode=1: lane i goes IDLE at (0,0). This overrides a same-edge frame update of that lane.
- Frame update, per ACTIVE lane i, evaluated on pre-edge values:
  - Ship hit: y_i>=415 and spaceship_xCoord-20 <= x_i <= spaceship_xCoord+20 -> IDLE. The spaceship samples the same pre-edge values on the same edge, so it sees the hit exactly once.
  - Otherwise, y_i+MOVE_DOWN > 475 -> IDLE (bottom exit).
  - Otherwise y_i <= y_i+MOVE_DOWN; x_i unchanged.
- Fire logic, frame_tick and mode=1:
  - Cooldown nonzero: decrement.
  - Cooldown zero: reload FIRE_PERIOD-1; lane L = LFSR[1:0] (pre-advance value).
  - L==3, lane L ACTIVE at start of frame, or alien_alive[L]==0: no fire.
  - Otherwise lane L goes ACTIVE with x=alien_x[L], y=alien_y[L]+13 (alien half-height 8 + laser half-height 5).
  - A lane retired on this frame is not refired on the same frame.
- Arithmetic: 10-bit unsigned throughout. Ship window bounds are computed with spaceship_xCoord clamped to >=20 to avoid wrap.
- Pixel outputs, combinational from registers:
  - is_alien_laser = OR over ACTIVE lanes of (|xCoord-x_i|<=1 && |yCoord-y_i|<=5).
  - rgb_alien_laser = COLOR_ALIEN_LASER when is_alien_laser, else 0.
  - Box compares are done as lower/upper bounds with saturating subtract.
- Packed outputs are driven directly from lane registers, lane i at [10i+9:10i].

Decomposition:
- Shared package game_pkg: screen edges (0/640/0/480), SCOREBOARD_BOTTOM=60, SPACESHIP_TOP=415 window, HALF_SPACESHIP_LENGTH=20, HALF_ALIEN_HEIGHT=8, HALF_LASER_HEIGHT=5, HALF_LASER_LENGTH=1, colour constants.
- Sub-module alien_laser_lane, instantiated ×3:
  - holds state/x/y; inputs fire, spawn_x, spawn_y, barrier_hit, frame_tick, mode, spaceship_xCoord, pixel x/y;
  - outputs x, y, active, pixel_hit.
- LFSR and cooldown stay in the top.

Test Plan:
- Reset check: assert restart mid-frame -> immediately all six packed coords 0, is_alien_laser=0. After release, LFSR=8'hA5 and the first fire attempt occurs on frame FIRE_PERIOD.
- Fire and descend: mode=1, all aliens alive at y=100, bench LFSR model selects lane 1 with alien1 x=200 -> lane 1 spawns at (200,113), then y=115, 117, … per frame. Pixel (200,113) gives is_alien_laser=1, rgb=8'b00000111; pixel (202,113) gives 0.
- Bottom exit: lane at y=474, MOVE_DOWN=2 -> next frame IDLE, coords (0,0).
- Ship hit: lane at (300,415), spaceship_xCoord=310 -> IDLE on next frame_tick. Repeat with spaceship_xCoord=330 -> continues to y=417.
- Barrier hit collides with frame: barrAlienLaserHit[0]=1 on the frame_tick edge -> lane 0 IDLE and not advanced; same edge with mode=0 -> all lanes IDLE.
- Dead or busy lane: LFSR selects lane 2 with alien_alive[2]=0, or lane 2 already ACTIVE -> no spawn, cooldown reloads to FIRE_PERIOD-1.
